// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with CSR register window
//
// Purpose: NUM_CH PWM channels that share one prescaler and one period counter.
//    PERIOD, PRESC and DUTY[i] are written into pending registers. They are copied
//    into the active shadows only at a period boundary, so a waveform never changes
//    in the middle of a period. CTRL and POL take effect at once.
// Ports:
//    clk      system clock; all logic runs on its rising edge
//    rst      synchronous active-high reset
//    pwm_ce   one-cycle base tick strobe
//    csr_a    CSR word address
//    csr_di   CSR write data
//    csr_we   CSR write strobe
//    csr_do   combinational CSR read data
//    pwm_en   per-channel enable (the CTRL register)
//    pwm_out  registered per-channel PWM output
module pwm_multi #(
   parameter logic [4:0] BASE_ADDR  = 5'h0c,
   parameter int         NUM_CH     = 4,
   parameter bit         CHECK_ADDR = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_ce,
   input  logic [4:0]        csr_a,
   input  logic [7:0]        csr_di,
   input  logic              csr_we,
   output logic [7:0]        csr_do,
   output logic [NUM_CH-1:0] pwm_en,
   output logic [NUM_CH-1:0] pwm_out
);

   localparam int NREG = 4 + NUM_CH;

   logic [NUM_CH-1:0] ctrl;
   logic [NUM_CH-1:0] pol;
   logic [7:0]        period_p;
   logic [7:0]        period_a;
   logic [1:0]        presc_p;
   logic [1:0]        presc_a;
   logic [7:0]        duty_p [NUM_CH];
   logic [7:0]        duty_a [NUM_CH];
   logic [2:0]        pcnt;
   logic [7:0]        cnt;

   logic [5:0]        off6;
   logic              in_win;
   logic [2:0]        pmax;
   logic              tick;
   logic [NUM_CH-1:0] out_nxt;

   // The offset is computed one bit wider so that addresses below BASE_ADDR
   // cannot wrap around into the window.
   assign off6   = {1'b0, csr_a} - {1'b0, BASE_ADDR};
   assign in_win = (csr_a >= BASE_ADDR) && (off6 < 6'(NREG));
   assign pwm_en = ctrl;

   // Prescaler terminal count is (2^PRESC)-1.
   always_comb begin
      case (presc_a)
         2'd0:    pmax = 3'd0;
         2'd1:    pmax = 3'd1;
         2'd2:    pmax = 3'd3;
         default: pmax = 3'd7;
      endcase
   end

   assign tick = pwm_ce && (pcnt == pmax);

   always_comb begin
      out_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         out_nxt[i] = ctrl[i] & ((cnt < duty_a[i]) ^ pol[i]);
      end
   end

   // Reads return the pending values, not the active shadows.
   always_comb begin
      csr_do = 8'h00;
      if (!CHECK_ADDR || in_win) begin
         case (off6)
            6'd0: for (int i = 0; i < NUM_CH; i++) csr_do[i] = ctrl[i];
            6'd1: for (int i = 0; i < NUM_CH; i++) csr_do[i] = pol[i];
            6'd2: csr_do = period_p;
            6'd3: csr_do = {6'd0, presc_p};
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (off6 == 6'(4 + i)) csr_do = duty_p[i];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl     <= '0;
         pol      <= '0;
         period_p <= '0;
         period_a <= '0;
         presc_p  <= '0;
         presc_a  <= '0;
         pcnt     <= '0;
         cnt      <= '0;
         pwm_out  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_p[i] <= '0;
            duty_a[i] <= '0;
         end
      end else begin
         pwm_out <= out_nxt;

         if (pwm_ce) begin
            pcnt <= tick ? 3'd0 : pcnt + 3'd1;
         end

         // The boundary reads the pending registers before this cycle's write
         // lands, so a write in the same cycle waits for the next boundary.
         if (tick) begin
            if (cnt == period_a) begin
               cnt      <= 8'd0;
               period_a <= period_p;
               presc_a  <= presc_p;
               for (int i = 0; i < NUM_CH; i++) duty_a[i] <= duty_p[i];
            end else begin
               cnt <= cnt + 8'd1;
            end
         end

         if (csr_we && in_win) begin
            case (off6)
               6'd0: ctrl     <= csr_di[NUM_CH-1:0];
               6'd1: pol      <= csr_di[NUM_CH-1:0];
               6'd2: period_p <= csr_di;
               6'd3: presc_p  <= csr_di[1:0];
               default: begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (off6 == 6'(4 + i)) duty_p[i] <= csr_di;
                  end
               end
            endcase
         end
      end
   end

endmodule
